// File: rtl/ax_level_governor.sv
// Closed-loop approximation-level governor: counts commit-stage errors per window
// and nudges the CSR AXLEVEL register up or down against the AXTHRESHOLD budget.
module ax_level_governor #(
  parameter int AX_LEVEL_WIDTH = 3,
  parameter int WINDOW_WIDTH   = 10,
  parameter int HOLD_CYCLES    = 16,
  parameter int ERR_WIDTH      = 32,
  parameter int ERR_INC_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      govEnable,
  input  logic [AX_LEVEL_WIDTH-1:0] axLevel,
  input  logic [31:0]               axThreshold,
  input  logic [ERR_INC_WIDTH-1:0]  errInc,
  input  logic                      csrAxLevelWrite,
  output logic                      axLevelEn,
  output logic [AX_LEVEL_WIDTH-1:0] axLevelData,
  output logic [1:0]                govState
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_DECIDE  = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]         HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WINDOW_WIDTH-1:0]   WIN_LAST  = '1;
  localparam logic [AX_LEVEL_WIDTH-1:0] LEVEL_MAX = '1;

  logic [1:0]                state_reg, state_next;
  logic [WINDOW_WIDTH-1:0]   win_cnt_reg, win_cnt_next;
  logic [ERR_WIDTH-1:0]      err_acc_reg, err_acc_next;
  logic [HOLD_W-1:0]         hold_cnt_reg, hold_cnt_next;
  logic                      pulse_reg, pulse_next;
  logic [AX_LEVEL_WIDTH-1:0] data_reg, data_next;

  logic [ERR_WIDTH:0]        acc_sum;
  logic [ERR_WIDTH-1:0]      acc_sat;
  logic [31:0]               acc_wide;
  logic                      lower_level;
  logic                      raise_level;
  logic [AX_LEVEL_WIDTH-1:0] target_level;

  // Saturating accumulate so a burst of errors can never wrap back under budget.
  assign acc_sum = {1'b0, err_acc_reg} + (ERR_WIDTH + 1)'(errInc);
  assign acc_sat = acc_sum[ERR_WIDTH] ? '1 : acc_sum[ERR_WIDTH-1:0];

  assign acc_wide     = 32'(err_acc_reg);
  assign lower_level  = (acc_wide > axThreshold) && (axLevel != '0);
  assign raise_level  = !lower_level && (acc_wide <= {1'b0, axThreshold[31:1]})
                        && (axLevel != LEVEL_MAX);
  assign target_level = lower_level ? (axLevel - AX_LEVEL_WIDTH'(1))
                                    : (axLevel + AX_LEVEL_WIDTH'(1));

  always_comb begin
    state_next    = state_reg;
    win_cnt_next  = win_cnt_reg;
    err_acc_next  = err_acc_reg;
    hold_cnt_next = hold_cnt_reg;
    pulse_next    = 1'b0;
    data_next     = data_reg;

    if (!govEnable) begin
      state_next    = S_IDLE;
      win_cnt_next  = '0;
      err_acc_next  = '0;
      hold_cnt_next = '0;
    end else if (csrAxLevelWrite && (state_reg != S_IDLE)) begin
      // Software took control of the level: discard this measurement and restart.
      state_next    = S_MEASURE;
      win_cnt_next  = '0;
      err_acc_next  = '0;
      hold_cnt_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          win_cnt_next  = '0;
          err_acc_next  = '0;
          hold_cnt_next = '0;
          state_next    = S_MEASURE;
        end
        S_MEASURE: begin
          err_acc_next = acc_sat;
          win_cnt_next = win_cnt_reg + WINDOW_WIDTH'(1);
          if (win_cnt_reg == WIN_LAST) begin
            state_next = S_DECIDE;
          end
        end
        S_DECIDE: begin
          win_cnt_next  = '0;
          err_acc_next  = '0;
          hold_cnt_next = '0;
          if (lower_level || raise_level) begin
            pulse_next = 1'b1;
            data_next  = target_level;
            state_next = S_HOLD;
          end else begin
            state_next = S_MEASURE;
          end
        end
        S_HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_next = '0;
            state_next    = S_MEASURE;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      win_cnt_reg  <= '0;
      err_acc_reg  <= '0;
      hold_cnt_reg <= '0;
      pulse_reg    <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      win_cnt_reg  <= win_cnt_next;
      err_acc_reg  <= err_acc_next;
      hold_cnt_reg <= hold_cnt_next;
      pulse_reg    <= pulse_next;
      data_reg     <= data_next;
    end
  end

  // A same-cycle software write suppresses the strobe; it is never replayed.
  assign axLevelEn   = pulse_reg & ~csrAxLevelWrite;
  assign axLevelData = data_reg;
  assign govState    = state_reg;

endmodule

// File: tb/tb_ax_level_governor.sv
// Randomized window scenarios for ax_level_governor, checked against a
// window-level model of the decision rule and the resulting state schedule.
module tb_ax_level_governor;

  localparam int AXW  = 3;
  localparam int WW   = 4;
  localparam int HC   = 4;
  localparam int EW   = 5;
  localparam int EIW  = 2;
  localparam int WIN  = 1 << WW;
  localparam int LMAX = (1 << AXW) - 1;
  localparam int SAT  = (1 << EW) - 1;

  logic           clk;
  logic           rst;
  logic           govEnable;
  logic [AXW-1:0] axLevel;
  logic [31:0]    axThreshold;
  logic [EIW-1:0] errInc;
  logic           csrAxLevelWrite;
  logic           axLevelEn;
  logic [AXW-1:0] axLevelData;
  logic [1:0]     govState;

  ax_level_governor #(
    .AX_LEVEL_WIDTH(AXW),
    .WINDOW_WIDTH  (WW),
    .HOLD_CYCLES   (HC),
    .ERR_WIDTH     (EW),
    .ERR_INC_WIDTH (EIW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .govEnable      (govEnable),
    .axLevel        (axLevel),
    .axThreshold    (axThreshold),
    .errInc         (errInc),
    .csrAxLevelWrite(csrAxLevelWrite),
    .axLevelEn      (axLevelEn),
    .axLevelData    (axLevelData),
    .govState       (govState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int errs[WIN];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int k);
    foreach (errs[i]) errs[i] = k;
  endtask

  task automatic fill_first(input int n);
    foreach (errs[i]) errs[i] = (i < n) ? 1 : 0;
  endtask

  task automatic fill_rand();
    int k;
    k = $urandom_range(0, 3);
    foreach (errs[i]) errs[i] = $urandom_range(0, k);
  endtask

  // Starts in an IDLE cycle (cycle 0), runs one measurement window and its
  // aftermath, then drops govEnable and leaves the DUT in IDLE again.
  task automatic run_window(input int lvl, input int thr, input int csr_off, input bit drop);
    int b, sum, tgt, last, st;
    bit change, en;
    b = drop ? 11 : 0;
    sum = 0;
    foreach (errs[i]) sum += errs[i];
    if (sum > SAT) sum = SAT;
    change = 1'b0;
    tgt = lvl;
    if (sum > thr && lvl != 0) begin
      change = 1'b1;
      tgt = lvl - 1;
    end else if (sum <= thr / 2 && lvl != LMAX) begin
      change = 1'b1;
      tgt = lvl + 1;
    end
    if (csr_off == 17)                  last = b + 34;
    else if (change && csr_off == 18)   last = b + 35;
    else if (change)                    last = b + 22;
    else                                last = b + 18;
    $display("scenario lvl=%0d thr=%0d sum=%0d csr_at=%0d drop=%0d change=%0d target=%0d",
             lvl, thr, sum, csr_off, drop, change, tgt);

    govEnable       = 1'b1;
    csrAxLevelWrite = 1'($urandom_range(0, 1));
    errInc          = EIW'($urandom_range(0, 3));
    axLevel         = AXW'($urandom_range(0, LMAX));
    axThreshold     = $urandom_range(0, 63);

    for (int c = 1; c <= last; c++) begin
      tick();
      govEnable       = !(c == last || (drop && c == 10));
      axLevel         = (c == b + 17) ? AXW'(lvl) : AXW'($urandom_range(0, LMAX));
      axThreshold     = (c == b + 17) ? 32'(thr) : 32'($urandom_range(0, 63));
      if (drop && c <= 10)             errInc = 2'd3;
      else if (c > b && c <= b + WIN)  errInc = EIW'(errs[c - b - 1]);
      else                             errInc = EIW'($urandom_range(0, 3));
      csrAxLevelWrite = (csr_off != 0 && c == b + csr_off) ||
                        (drop && c == 11 && $urandom_range(0, 1) == 1);
      #1;
      if (drop && c <= 10)                st = 1;
      else if (drop && c == 11)           st = 0;
      else if (c <= b + WIN)              st = 1;
      else if (c == b + 17)               st = 2;
      else if (csr_off == 17)             st = (c == b + 34) ? 2 : 1;
      else if (change && csr_off == 18)   st = (c == b + 18) ? 3 : ((c == b + 35) ? 2 : 1);
      else if (change)                    st = (c <= b + 21) ? 3 : 1;
      else                                st = 1;
      en = change && csr_off == 0 && c == b + 18;
      check_val("govState", 32'(govState), 32'(st));
      check_val("axLevelEn", 32'(axLevelEn), 32'(en));
      if (change && csr_off != 17 && c == b + 18)
        check_val("axLevelData", 32'(axLevelData), 32'(tgt));
    end

    tick();
    govEnable       = 1'b0;
    csrAxLevelWrite = 1'b0;
    #1;
    check_val("idle_state", 32'(govState), 32'd0);
    check_val("idle_en", 32'(axLevelEn), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, csr_off;
    rst             = 1'b1;
    govEnable       = 1'b0;
    axLevel         = '0;
    axThreshold     = '0;
    errInc          = '0;
    csrAxLevelWrite = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      govEnable       = 1'($urandom_range(0, 1));
      csrAxLevelWrite = 1'($urandom_range(0, 1));
      errInc          = EIW'($urandom_range(0, 3));
      axLevel         = AXW'($urandom_range(0, LMAX));
      axThreshold     = $urandom;
      #1;
      check_val("rst_state", 32'(govState), 32'd0);
      check_val("rst_en", 32'(axLevelEn), 32'd0);
      check_val("rst_data", 32'(axLevelData), 32'd0);
    end
    rst       = 1'b0;
    govEnable = 1'b0;
    tick();
    check_val("post_rst_state", 32'(govState), 32'd0);
    check_val("post_rst_en", 32'(axLevelEn), 32'd0);
    check_val("post_rst_data", 32'(axLevelData), 32'd0);

    fill_const(1); run_window(3, 10, 0, 1'b0);
    fill_const(0); run_window(3, 10, 0, 1'b0);
    fill_const(0); run_window(7, 10, 0, 1'b0);
    fill_first(8); run_window(3, 10, 0, 1'b0);
    fill_const(3); run_window(0, 30, 0, 1'b0);
    fill_const(3); run_window(1, 30, 0, 1'b0);
    fill_const(1); run_window(3, 10, 17, 1'b0);
    fill_const(1); run_window(3, 10, 18, 1'b0);
    fill_const(0); run_window(3, 10, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      fill_rand();
      r = $urandom_range(0, 5);
      csr_off = (r == 0) ? 17 : ((r == 1) ? 18 : 0);
      run_window($urandom_range(0, LMAX), $urandom_range(0, 40), csr_off,
                 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
